// File: rtl/branch_predictor.sv
// branch_predictor
//   Fetch-stage branch predictor: a direct-mapped branch target buffer whose
//   entries carry a 2-bit saturating direction counter. Fetch lookup is
//   combinational; training comes from the execute stage at the clock edge.
//   The execute-stage outcome is also compared against the piped prediction
//   to raise a flush request and supply the corrected fetch PC.
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-high reset
//   fetchPC          PC being fetched this cycle
//   predictTaken     1 = redirect fetch to predictTarget
//   predictTarget    stored target on a hit, 0 otherwise
//   updateValid      EX stage holds a resolved conditional branch
//   updatePC         PC of the resolved branch
//   updateTaken      actual branch outcome
//   updateTarget     computed branch target
//   updatePredTaken  prediction made for this branch at fetch
//   mispredict       flush request for younger instructions
//   redirectPC       correct next PC, meaningful only while mispredict=1
module branch_predictor #(
  parameter int unsigned INDEX_BITS   = 6,
  parameter logic [1:0]  COUNTER_INIT = 2'b10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetchPC,
  output logic        predictTaken,
  output logic [31:0] predictTarget,
  input  logic        updateValid,
  input  logic [31:0] updatePC,
  input  logic        updateTaken,
  input  logic [31:0] updateTarget,
  input  logic        updatePredTaken,
  output logic        mispredict,
  output logic [31:0] redirectPC
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W   = 32 - INDEX_BITS - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] f_idx, u_idx;
  logic [TAG_W-1:0]      f_tag, u_tag;
  logic                  f_hit, u_hit;
  logic [1:0]            u_ctr_d;

  assign f_idx = fetchPC[INDEX_BITS+1:2];
  assign f_tag = fetchPC[31:INDEX_BITS+2];
  assign u_idx = updatePC[INDEX_BITS+1:2];
  assign u_tag = updatePC[31:INDEX_BITS+2];

  // Lookup reads the registered array, so a same-cycle write is not visible.
  // Reset forces a miss so nothing stale is predicted in the reset cycle.
  assign f_hit = !reset && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  always_comb begin
    predictTaken  = 1'b0;
    predictTarget = '0;
    if (f_hit) begin
      predictTaken  = ctr_q[f_idx][1];
      predictTarget = target_q[f_idx];
    end
  end

  // Saturating counter step for the entry being trained.
  always_comb begin
    u_ctr_d = ctr_q[u_idx];
    if (updateTaken) begin
      if (ctr_q[u_idx] != 2'b11) u_ctr_d = ctr_q[u_idx] + 2'd1;
    end else begin
      if (ctr_q[u_idx] != 2'b00) u_ctr_d = ctr_q[u_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (updateValid) begin
      if (u_hit) begin
        ctr_q[u_idx] <= u_ctr_d;
        if (updateTaken) target_q[u_idx] <= updateTarget;
      end else if (updateTaken) begin
        // Direct-mapped replacement: only a taken miss evicts an alias.
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= updateTarget;
        ctr_q[u_idx]    <= COUNTER_INIT;
      end
    end
  end

  assign mispredict = !reset && updateValid && (updateTaken != updatePredTaken);
  assign redirectPC = updateTaken ? updateTarget : (updatePC + 32'd4);

endmodule
